// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux_sched round-robin burst scheduler.
package demux_sched_pkg;

   localparam int unsigned NUM_CH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   typedef logic [1:0] ch_t;

endpackage

// File: rtl/demux_sched_rr_pick.sv
// Combinational rotating-priority picker: searches last+1, last+2, last+3, last.
import demux_sched_pkg::*;

module rr_pick (
   input  logic [NUM_CH-1:0] req,
   input  ch_t               last,
   output ch_t               gnt_idx,
   output logic              gnt_any
);

   ch_t w_idx;

   always_comb begin
      gnt_idx = last;
      gnt_any = 1'b0;
      w_idx   = '0;
      // i == NUM_CH wraps back to 'last', giving it lowest priority
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         w_idx = last + ch_t'(i);
         if (!gnt_any && req[w_idx]) begin
            gnt_idx = w_idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_sched.sv
// Round-robin burst scheduler steering one valid/ready stream to four channels.
import demux_sched_pkg::*;

module demux_sched #(
   parameter int W     = 8,
   parameter int BURST = 4,
   localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en_mask,
   input  logic              in_valid,
   input  logic [W-1:0]      in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic [NUM_CH-1:0] out_valid,
   output logic [W-1:0]      out_data,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [1:0]        sel,
   output logic              busy,
   output logic [CW-1:0]     beat_cnt
);

   state_t        r_state, w_state_nxt;
   ch_t           r_sel, w_sel_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   ch_t  w_gnt_idx;
   logic w_gnt_any;
   logic w_xfer;

   rr_pick u_rr_pick (
      .req     (en_mask & out_ready),
      .last    (r_sel),
      .gnt_idx (w_gnt_idx),
      .gnt_any (w_gnt_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel   <= 2'd3;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign w_xfer = (r_state == XFER) && in_valid && out_ready[r_sel];

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (in_valid && w_gnt_any) begin
               w_sel_nxt   = w_gnt_idx;
               w_cnt_nxt   = '0;
               w_state_nxt = XFER;
            end
         end
         XFER: begin
            if (w_xfer) begin
               if (r_cnt == CW'(BURST - 1) || in_last) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign out_data  = in_data;
   assign in_ready  = (r_state == XFER) && out_ready[r_sel];
   assign out_valid = ((r_state == XFER) && in_valid) ? (NUM_CH'(1) << r_sel) : '0;
   assign busy      = (r_state == XFER);
   assign sel       = r_sel;
   assign beat_cnt  = r_cnt;

endmodule

// File: doc/demux_sched.md
Name: demux_sched

Overview:
- Round-robin burst scheduler that shares one input stream among four destination channels.
- Sequences a 1-to-4 demultiplexer: grants one channel at a time, holds the select for a burst, then rotates.
- Sits between a single producer and four consumers.
- Provides valid/ready handshakes on both sides and a per-channel enable mask for software configuration.

Parameters:
- W, 8, data width of in_data/out_data
- BURST, 4, maximum beats per grant (>=1); burst ends early on in_last
- CW, $clog2(BURST) (min 1), beat counter width (derived; not overridden)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous reset, active-high
- en_mask  in  4  per-channel enable; only enabled channels are eligible for a grant
- in_valid  in  1  producer beat valid
- in_data  in  W  producer beat data
- in_last  in  1  final beat of a burst; qualified by in_valid
- in_ready  out  1  producer may transfer this cycle
- out_valid  out  4  one-hot valid to the channels; bit k means channel k
- out_data  out  W  shared data bus to all channels (equals in_data)
- out_ready  in  4  per-channel consumer ready
- sel  out  2  current or last granted channel (registered)
- busy  out  1  1 while in XFER
- beat_cnt  out  CW  beats accepted in the current burst (registered)

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=2'd3 (so the first grant searches from channel 0), beat_cnt=0, busy=0.
  - out_valid=0 and in_ready=0 throughout reset.
  - Reset mid-burst aborts the burst immediately. Partial bursts are not resumed.
- Handshake: a beat transfers on a cycle with in_valid && in_ready. Channel k sees out_valid[k] && out_ready[k] on the same cycle.
- Datapath is combinational in XFER, so data latency is 0 cycles.
  - out_data = in_data always.
  - out_valid = in_valid one-hot at sel.
  - in_ready = out_ready[sel].
- State IDLE:
  - Outputs: out_valid=0, in_ready=0, busy=0.
  - Eligible set E = en_mask & out_ready.
  - If in_valid && E!=0: pick the first k in E searching sel+1, sel+2, sel+3, sel (mod 4). Register sel=k, beat_cnt=0, go to XFER.
  - Otherwise remain in IDLE with sel unchanged.
  - Arbitration costs 1 cycle: the first beat cannot transfer in the cycle its grant is decided.
- State XFER:
  - busy=1.
  - On each transfer, beat_cnt increments.
  - The burst ends on the transfer where beat_cnt==BURST-1 or in_last=1. Go to IDLE with beat_cnt=0 and sel kept, so it becomes the round-robin pointer.
  - If the granted channel deasserts out_ready, stall: stay in XFER, no transfer. The grant does not move.
  - If in_valid drops mid-burst, stay in XFER and wait.
- en_mask changes:
  - Sampled only in IDLE.
  - Clearing the granted channel's bit mid-burst does not end the burst.
- en_mask=0: stays IDLE indefinitely; in_ready=0, nothing is dropped.
- Single eligible channel: it is re-granted every burst, with one IDLE cycle between bursts.
- BURST=1: every beat is its own burst, and the grant rotates per beat.
- beat_cnt wraps to 0 only via burst end. It never exceeds BURST-1.

Decomposition:
- Package demux_sched_pkg:
  - NUM_CH=4
  - state enum {IDLE, XFER}
  - channel index typedef (2 bits)
- Sub-module rr_pick (combinational): inputs req[3:0] and last[1:0]; outputs gnt_idx[1:0] and gnt_any. Rotating priority starts after last.
- demux_sched contains the FSM, beat counter and output muxing.

Test Plan:
- Reset then all channels enabled and ready, continuous in_valid, in_last=0, BURST=4 -> grants in order ch0,ch1,ch2,ch3,ch0. Each burst is exactly 4 transfers, with 1 idle cycle between bursts.
- in_last=1 on the 2nd beat of a ch1 burst -> burst ends after 2 transfers, and the next grant goes to ch2.
- en_mask=4'b1010, all ready -> grants alternate ch1,ch3,ch1. Channels 0 and 2 never see out_valid.
- out_ready[2]=0 for 5 cycles mid-burst (granted ch2, beat_cnt=1) -> in_ready=0, sel stays 2 and beat_cnt stays 1. The burst resumes and completes with 4 beats total.
- Assert rst asynchronously mid-burst (sel=1, beat_cnt=2) -> out_valid=0, in_ready=0 and busy=0 immediately. After release the first grant is ch0.
- en_mask=0 with in_valid=1 for 10 cycles -> no transfer and busy=0. Setting en_mask=4'b0100 then grants ch2 one cycle later.
